undo_log_writer: RTL and testbench
==================================

UNDO_LOG_WRITER -- requirements
Module: undo_log_writer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, power of two: entries buffered between the core and the AXI write path.
REQ-002 Parameter LOG_ENTRIES, default 16: maximum undo records per task.
REQ-003 ap_clk  in  1  sole clock; all logic on its rising edge.
REQ-004 ap_rst  in  1  reset, asynchronous, active-high.
REQ-005 log_base  in  32  byte address of the current task's undo region; 8-byte aligned; stable while log_idle=0.
REQ-006 task_begin  in  1  one-cycle pulse that starts a new task's log.
REQ-007 undo_log_entry  in  UNDO_LOG_ADDR_WIDTH+UNDO_LOG_DATA_WIDTH  packed as {data, addr}; both widths are 32.
REQ-008 undo_log_entry_ap_vld  in  1  entry valid for one cycle; there is no backpressure.
REQ-009 log_count  out  $clog2(LOG_ENTRIES)+1  number of entries accepted since the last task_begin.
REQ-010 log_idle  out  1  FIFO empty and no AXI transaction outstanding.
REQ-011 log_overflow  out  1  sticky: at least one entry was dropped.
REQ-012 log_error  out  1  sticky: a non-OKAY BRESP was received.
REQ-013 m_axi_l1_V_AW{VALID,READY,ADDR[31:0],LEN[7:0],SIZE[2:0]}, m_axi_l1_V_W{VALID,READY,DATA[31:0],STRB[3:0],LAST} and m_axi_l1_V_B{VALID,READY,RESP[1:0],ID} form a standard AXI4 write master.

Function
REQ-014 Entry acceptance:
- Condition: vld=1, FIFO not full, and log_count<LOG_ENTRIES.
- Action: push {entry, index=log_count} and increment log_count.
REQ-015 Drop rule: vld=1 while the FIFO is full or log_count==LOG_ENTRIES drops the entry, sets log_overflow, and leaves log_count unchanged.
REQ-016 Simultaneous push and pop in the same cycle are both honored; a full FIFO that pops in the same cycle accepts the incoming entry.
REQ-017 Write FSM states: IDLE, AWADDR, WDATA0, WDATA1, BWAIT.
REQ-018 IDLE: moves to AWADDR the cycle after the FIFO becomes non-empty; the head entry is latched on that transition and popped.
REQ-019 AWADDR: drives AWVALID=1, AWADDR=log_base+index*8, AWLEN=1, AWSIZE=3'b010; moves to WDATA0 on AWREADY.
REQ-020 WDATA0: drives WVALID=1, WDATA=entry addr, WSTRB=4'hF, WLAST=0; moves to WDATA1 on WREADY.
REQ-021 WDATA1: drives WVALID=1, WDATA=entry data, WLAST=1; moves to BWAIT on WREADY.
REQ-022 BWAIT: drives BREADY=1; on BVALID, sets log_error if BRESP!=0, then moves to IDLE.
REQ-023 AWVALID and WVALID never assert in the same cycle; AWVALID holds, with stable address, until AWREADY is seen.
REQ-024 task_begin handling:
- Honored only when log_idle=1; then log_count and log_overflow clear next cycle.
- Ignored when log_idle=0.
REQ-025 A vld in the same cycle as an honored task_begin is accepted as index 0, and log_count becomes 1.
REQ-026 log_idle is combinational: FIFO empty and FSM in IDLE.
REQ-027 Minimum latency from vld to AWVALID is 2 cycles.
REQ-028 Arithmetic: index*8 is computed in 32 bits with no wrap check; log_count saturates at LOG_ENTRIES.

Reset
REQ-029 While ap_rst=1, asynchronously:
- FSM goes to IDLE, FIFO pointers clear, log_count=0, log_overflow=0, log_error=0.
- All AXI VALID/READY outputs go to 0; log_idle=1.
REQ-030 Reset asserted mid-burst abandons the transaction immediately, with no completion.

Structure
REQ-031 UNDO_LOG_ADDR_WIDTH, UNDO_LOG_DATA_WIDTH, undo_log_addr_t and undo_log_data_t are defined in package swarm.
REQ-032 The FSM state enum is local to the module.
REQ-033 The FIFO is one sub-module, undo_log_fifo: synchronous, with push, pop, full and empty.

Verification
REQ-034 Single entry: vld with {data=0x0000_1234, addr=0x40}, log_base=0x1000.
- AW addr 0x1000, LEN=1; W beats 0x40 then 0x1234, WLAST on beat 2.
- log_count=1; log_idle returns to 1 after BVALID.
REQ-035 Back-to-back: 3 vld pulses on consecutive cycles with AWREADY held low 10 cycles. Response: no drop; addresses 0x1000, 0x1008, 0x1010 issued in order.
REQ-036 FIFO full: 6 consecutive vld pulses with FIFO_DEPTH=4 and the AXI stalled. Response: exactly one entry dropped, log_overflow=1, log_count=5.
REQ-037 Capacity: 17 spaced vld pulses with LOG_ENTRIES=16. Response: 16 writes issued; the 17th is dropped, log_overflow=1.
REQ-038 task_begin timing:
- task_begin while BWAIT: ignored.
- task_begin after idle, with a same-cycle vld: log_count=1, write to log_base+0.
REQ-039 Error and reset:
- BRESP=2'b10: log_error=1 and sticky across a following task_begin.
- ap_rst during WDATA1: WVALID drops the same cycle, all outputs at reset values.

Source files
------------

// File: rtl/swarm_pkg.sv
// Shared undo-log types and AXI constants for the swarm task-logging blocks.
package swarm;
  localparam int UNDO_LOG_ADDR_WIDTH = 32;
  localparam int UNDO_LOG_DATA_WIDTH = 32;

  typedef logic [UNDO_LOG_ADDR_WIDTH-1:0] undo_log_addr_t;
  typedef logic [UNDO_LOG_DATA_WIDTH-1:0] undo_log_data_t;

  // Every record goes out as one two-beat, 4-byte-wide burst.
  localparam logic [7:0] AXI_LEN_TWO_BEATS = 8'd1;
  localparam logic [2:0] AXI_SIZE_4B       = 3'b010;
  localparam logic [3:0] AXI_STRB_ALL      = 4'hF;
  localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
endpackage

// File: rtl/undo_log_fifo.sv
// Synchronous FIFO between the core-side entry port and the AXI write FSM.
module undo_log_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 69
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // Extra MSB on each pointer distinguishes full from empty.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

// File: rtl/undo_log_writer.sv
// Buffers undo-log records from the core and writes each as an {addr, data}
// pair to log_base + index*8 over a single-outstanding AXI4 write master.
module undo_log_writer
  import swarm::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int LOG_ENTRIES = 16
) (
  input  logic                                         ap_clk,
  input  logic                                         ap_rst,
  input  logic [31:0]                                  log_base,
  input  logic                                         task_begin,
  input  logic [UNDO_LOG_ADDR_WIDTH+UNDO_LOG_DATA_WIDTH-1:0] undo_log_entry,
  input  logic                                         undo_log_entry_ap_vld,
  output logic [$clog2(LOG_ENTRIES):0]                 log_count,
  output logic                                         log_idle,
  output logic                                         log_overflow,
  output logic                                         log_error,
  output logic                                         m_axi_l1_V_AWVALID,
  input  logic                                         m_axi_l1_V_AWREADY,
  output logic [31:0]                                  m_axi_l1_V_AWADDR,
  output logic [7:0]                                   m_axi_l1_V_AWLEN,
  output logic [2:0]                                   m_axi_l1_V_AWSIZE,
  output logic                                         m_axi_l1_V_WVALID,
  input  logic                                         m_axi_l1_V_WREADY,
  output logic [31:0]                                  m_axi_l1_V_WDATA,
  output logic [3:0]                                   m_axi_l1_V_WSTRB,
  output logic                                         m_axi_l1_V_WLAST,
  input  logic                                         m_axi_l1_V_BVALID,
  output logic                                         m_axi_l1_V_BREADY,
  input  logic [1:0]                                   m_axi_l1_V_BRESP,
  input  logic                                         m_axi_l1_V_BID
);
  localparam int CNT_W   = $clog2(LOG_ENTRIES) + 1;
  localparam int ENTRY_W = UNDO_LOG_DATA_WIDTH + UNDO_LOG_ADDR_WIDTH + CNT_W;

  typedef enum logic [2:0] {IDLE, AWADDR, WDATA0, WDATA1, BWAIT} state_t;

  state_t         state;
  state_t         state_next;
  logic           fifo_full;
  logic           fifo_empty;
  logic           fifo_pop;
  logic           fifo_push;
  logic [ENTRY_W-1:0] fifo_rdata;
  logic           task_go;
  logic [CNT_W-1:0] base_count;
  logic           drop;
  undo_log_addr_t cur_addr;
  undo_log_data_t cur_data;
  logic [CNT_W-1:0] cur_index;
  logic           unused_bid;

  assign unused_bid = m_axi_l1_V_BID;

  // Entry acceptance: a same-cycle pop frees the slot, and an honored
  // task_begin restarts numbering at zero for the incoming entry.
  assign log_idle   = fifo_empty && (state == IDLE);
  assign task_go    = task_begin && log_idle;
  assign base_count = task_go ? '0 : log_count;
  assign fifo_pop   = (state == IDLE) && !fifo_empty;
  assign fifo_push  = undo_log_entry_ap_vld && (!fifo_full || fifo_pop)
                      && (base_count < CNT_W'(LOG_ENTRIES));
  assign drop       = undo_log_entry_ap_vld && !fifo_push;

  undo_log_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clk  (ap_clk),
    .rst  (ap_rst),
    .push (fifo_push),
    .pop  (fifo_pop),
    .wdata({undo_log_entry, base_count}),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      log_count    <= '0;
      log_overflow <= 1'b0;
      log_error    <= 1'b0;
    end else begin
      log_count <= base_count + CNT_W'(fifo_push);
      if (drop)         log_overflow <= 1'b1;
      else if (task_go) log_overflow <= 1'b0;
      if ((state == BWAIT) && m_axi_l1_V_BVALID && (m_axi_l1_V_BRESP != AXI_RESP_OKAY))
        log_error <= 1'b1;
    end
  end

  // Head entry captured as it leaves the FIFO; held for the whole burst.
  always_ff @(posedge ap_clk) begin
    if (fifo_pop) {cur_data, cur_addr, cur_index} <= fifo_rdata;
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!fifo_empty)          state_next = AWADDR;
      AWADDR:  if (m_axi_l1_V_AWREADY)   state_next = WDATA0;
      WDATA0:  if (m_axi_l1_V_WREADY)    state_next = WDATA1;
      WDATA1:  if (m_axi_l1_V_WREADY)    state_next = BWAIT;
      BWAIT:   if (m_axi_l1_V_BVALID)    state_next = IDLE;
      default:                           state_next = IDLE;
    endcase
  end

  always_comb begin
    m_axi_l1_V_AWVALID = 1'b0;
    m_axi_l1_V_AWADDR  = log_base + (32'(cur_index) << 3);
    m_axi_l1_V_AWLEN   = AXI_LEN_TWO_BEATS;
    m_axi_l1_V_AWSIZE  = AXI_SIZE_4B;
    m_axi_l1_V_WVALID  = 1'b0;
    m_axi_l1_V_WDATA   = cur_addr;
    m_axi_l1_V_WSTRB   = AXI_STRB_ALL;
    m_axi_l1_V_WLAST   = 1'b0;
    m_axi_l1_V_BREADY  = 1'b0;
    case (state)
      AWADDR: m_axi_l1_V_AWVALID = 1'b1;
      WDATA0: m_axi_l1_V_WVALID  = 1'b1;
      WDATA1: begin
        m_axi_l1_V_WVALID = 1'b1;
        m_axi_l1_V_WDATA  = cur_data;
        m_axi_l1_V_WLAST  = 1'b1;
      end
      BWAIT:  m_axi_l1_V_BREADY  = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_undo_log_writer.sv
// Scoreboard bench for undo_log_writer with a small AXI write-slave model.
module tb_undo_log_writer;
  localparam int CNT_W = 5;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic [31:0] log_base;
  logic        task_begin;
  logic [63:0] undo_log_entry;
  logic        vld;
  logic [CNT_W-1:0] log_count;
  logic        log_idle, log_overflow, log_error;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic        bid;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] w0;
    logic [31:0] w1;
  } wr_t;

  wr_t         exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          n_writes = 0;
  logic        aw_en = 1'b1;
  logic        w_en = 1'b1;
  logic        b_hold = 1'b0;
  logic [1:0]  next_bresp = 2'b00;
  logic        b_pending = 1'b0;
  logic        b_hs, w_done;
  int          wbeat = 0;
  logic [31:0] beat0, cur_aw;

  assign awready = aw_en;
  assign wready  = w_en;
  assign bid     = 1'b0;

  always #5 ap_clk = ~ap_clk;

  undo_log_writer #(.FIFO_DEPTH(4), .LOG_ENTRIES(16)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .log_base(log_base), .task_begin(task_begin),
    .undo_log_entry(undo_log_entry), .undo_log_entry_ap_vld(vld),
    .log_count(log_count), .log_idle(log_idle), .log_overflow(log_overflow), .log_error(log_error),
    .m_axi_l1_V_AWVALID(awvalid), .m_axi_l1_V_AWREADY(awready), .m_axi_l1_V_AWADDR(awaddr),
    .m_axi_l1_V_AWLEN(awlen), .m_axi_l1_V_AWSIZE(awsize),
    .m_axi_l1_V_WVALID(wvalid), .m_axi_l1_V_WREADY(wready), .m_axi_l1_V_WDATA(wdata),
    .m_axi_l1_V_WSTRB(wstrb), .m_axi_l1_V_WLAST(wlast),
    .m_axi_l1_V_BVALID(bvalid), .m_axi_l1_V_BREADY(bready), .m_axi_l1_V_BRESP(bresp),
    .m_axi_l1_V_BID(bid)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Slave model and output monitor: sample on the falling edge, respond after the rising edge.
  initial begin
    wr_t e;
    bvalid = 1'b0;
    bresp  = 2'b00;
    forever begin
      @(negedge ap_clk);
      b_hs   = 1'b0;
      w_done = 1'b0;
      if (ap_rst) begin
        wbeat = 0;
      end else begin
        if (awvalid) check_val("aw_w_exclusive", wvalid, 0);
        if (awvalid && awready) begin
          cur_aw = awaddr;
          check_val("awlen", awlen, 1);
          check_val("awsize", awsize, 3'b010);
        end
        if (wvalid && wready) begin
          check_val("wstrb", wstrb, 4'hF);
          if (wbeat == 0) begin
            check_val("wlast_beat0", wlast, 0);
            beat0 = wdata;
            wbeat = 1;
          end else begin
            check_val("wlast_beat1", wlast, 1);
            wbeat  = 0;
            w_done = 1'b1;
            n_writes++;
            check_val("write_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              check_val("awaddr", cur_aw, e.addr);
              check_val("wbeat0", beat0, e.w0);
              check_val("wbeat1", wdata, e.w1);
            end
          end
        end
        b_hs = bvalid && bready;
      end
      @(posedge ap_clk);
      #1;
      if (ap_rst) begin
        bvalid    = 1'b0;
        b_pending = 1'b0;
      end else begin
        if (b_hs)   bvalid = 1'b0;
        if (w_done) b_pending = 1'b1;
        if (b_pending && !b_hold && !bvalid) begin
          bvalid    = 1'b1;
          bresp     = next_bresp;
          b_pending = 1'b0;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge ap_clk);
      #1;
    end
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] ea, input logic [31:0] ed);
    wr_t t;
    t.addr = a;
    t.w0   = ea;
    t.w1   = ed;
    exp_q.push_back(t);
  endtask

  task automatic send(input logic [31:0] ea, input logic [31:0] ed);
    undo_log_entry = {ed, ea};
    vld = 1'b1;
    tick(1);
    vld = 1'b0;
  endtask

  task automatic begin_task();
    task_begin = 1'b1;
    tick(1);
    task_begin = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!(log_idle && exp_q.size() == 0 && !bvalid) && n < 200) begin
      tick(1);
      n++;
    end
    check_val({tag, "_idle"}, {log_idle, exp_q.size() == 0}, 2'b11);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int n;
    int w;
    ap_rst = 1'b1;
    task_begin = 1'b0;
    vld = 1'b0;
    undo_log_entry = '0;
    log_base = 32'h1000;
    #2;
    check_val("reset_outputs", {awvalid, wvalid, bready, log_idle, log_overflow, log_error}, 6'b000100);
    check_val("reset_count", log_count, 0);
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    tick(1);

    // Single entry and vld-to-AWVALID latency
    push_exp(32'h1000, 32'h40, 32'h1234);
    send(32'h40, 32'h1234);
    check_val("lat_cycle1_awvalid", awvalid, 0);
    tick(1);
    check_val("lat_cycle2_awvalid", awvalid, 1);
    check_val("t1_count", log_count, 1);
    wait_idle("t1");

    // Back-to-back with AW stalled
    begin_task();
    aw_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_exp(32'h1000 + 32'(i) * 8, 32'h100 + 32'(i), 32'hA000 + 32'(i));
      undo_log_entry = {32'hA000 + 32'(i), 32'h100 + 32'(i)};
      vld = 1'b1;
      tick(1);
    end
    vld = 1'b0;
    tick(10);
    check_val("t2_count", log_count, 3);
    check_val("t2_no_overflow", log_overflow, 0);
    check_val("t2_aw_held", {awvalid, awaddr}, {1'b1, 32'h1000});
    aw_en = 1'b1;
    wait_idle("t2");

    // FIFO full: six consecutive entries, one dropped
    begin_task();
    aw_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) push_exp(32'h1000 + 32'(i) * 8, 32'h200 + 32'(i), 32'hB000 + 32'(i));
      undo_log_entry = {32'hB000 + 32'(i), 32'h200 + 32'(i)};
      vld = 1'b1;
      tick(1);
    end
    vld = 1'b0;
    tick(2);
    check_val("t3_count", log_count, 5);
    check_val("t3_overflow", log_overflow, 1);
    aw_en = 1'b1;
    wait_idle("t3");

    // Capacity limit
    log_base = 32'h2000;
    begin_task();
    check_val("t4_overflow_cleared", log_overflow, 0);
    check_val("t4_count_cleared", log_count, 0);
    w = n_writes;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) push_exp(32'h2000 + 32'(i) * 8, 32'h300 + 32'(i), 32'hC000 + 32'(i));
      send(32'h300 + 32'(i), 32'hC000 + 32'(i));
      wait_idle("t4_step");
    end
    check_val("t4_count", log_count, 16);
    check_val("t4_overflow", log_overflow, 1);
    check_val("t4_writes", n_writes - w, 16);

    // task_begin during BWAIT is ignored
    log_base = 32'h1000;
    begin_task();
    b_hold = 1'b1;
    push_exp(32'h1000, 32'h400, 32'hD000);
    send(32'h400, 32'hD000);
    n = 0;
    while (!bready && n < 50) begin
      tick(1);
      n++;
    end
    check_val("t5_in_bwait", {bready, log_idle}, 2'b10);
    begin_task();
    check_val("t5_tb_ignored_count", log_count, 1);
    b_hold = 1'b0;
    wait_idle("t5");

    // task_begin with same-cycle vld
    push_exp(32'h1000, 32'h500, 32'hE000);
    undo_log_entry = {32'hE000, 32'h500};
    task_begin = 1'b1;
    vld = 1'b1;
    tick(1);
    task_begin = 1'b0;
    vld = 1'b0;
    check_val("t6_count", log_count, 1);
    wait_idle("t6");

    // Error response is sticky across task_begin
    next_bresp = 2'b10;
    push_exp(32'h1008, 32'h600, 32'hF000);
    send(32'h600, 32'hF000);
    wait_idle("t7");
    check_val("t7_error", log_error, 1);
    next_bresp = 2'b00;
    begin_task();
    check_val("t7_error_sticky", log_error, 1);
    check_val("t7_count_cleared", log_count, 0);

    // Reset while in WDATA1
    w_en = 1'b0;
    send(32'h700, 32'h7777);
    n = 0;
    while (!wvalid && n < 50) begin
      tick(1);
      n++;
    end
    check_val("t8_in_wdata0", {wvalid, wlast}, 2'b10);
    w_en = 1'b1;
    tick(1);
    w_en = 1'b0;
    check_val("t8_in_wdata1", {wvalid, wlast, wdata}, {2'b11, 32'h7777});
    #2;
    ap_rst = 1'b1;
    #1;
    check_val("t8_reset_outputs", {awvalid, wvalid, bready, log_idle, log_overflow, log_error}, 6'b000100);
    check_val("t8_reset_count", log_count, 0);
    tick(2);
    exp_q.delete();
    ap_rst = 1'b0;
    w_en = 1'b1;
    tick(2);
    check_val("t8_no_restart", {awvalid, wvalid, log_idle}, 3'b001);

    // Normal operation after reset
    log_base = 32'h3000;
    push_exp(32'h3000, 32'h800, 32'h8888);
    send(32'h800, 32'h8888);
    wait_idle("t9");
    check_val("t9_count", log_count, 1);
    check_val("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
